// File: rtl/wbb_pkg.sv
// wbb_pkg: shared types and default sizing for the write-back buffer.
//   wbb_state_e  - buffer controller states
//   wbb_entry_t  - one buffered {valid, address, data} slot
//   WBB_*        - default geometry used by write_back_buffer and wbb_match
package wbb_pkg;

  localparam int WBB_DEPTH      = 4;
  localparam int WBB_HIGH_WATER = 3;
  localparam int WBB_ADDR_W     = 32;
  localparam int WBB_DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } wbb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [WBB_ADDR_W-1:0] addr;
    logic [WBB_DATA_W-1:0] data;
  } wbb_entry_t;

endpackage

// File: rtl/wbb_match.sv
// wbb_match: combinational youngest-match search over the buffer entries.
// Ports:
//   entries - buffer storage (circular, tail points at next free slot)
//   addr    - address to look up (full-width compare)
//   excl    - one-hot-or-zero mask of slots that must not match
//   tail    - write pointer; entries just behind it are the youngest
//   hit     - some valid, non-excluded entry matches addr
//   idx     - slot index of the youngest matching entry
//   data    - data of the youngest matching entry
module wbb_match import wbb_pkg::*; #(
  parameter  int DEPTH = WBB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wbb_entry_t            entries [DEPTH],
  input  logic [WBB_ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0]      excl,
  input  logic [PTR_W-1:0]      tail,
  output logic                  hit,
  output logic [PTR_W-1:0]      idx,
  output logic [WBB_DATA_W-1:0] data
);

  logic [PTR_W-1:0] pos_s;
  logic             match_s;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite earlier ones.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    data    = '0;
    pos_s   = '0;
    match_s = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos_s   = tail - PTR_W'(k);
      match_s = entries[pos_s].valid && !excl[pos_s] && (entries[pos_s].addr == addr);
      hit     = hit | match_s;
      idx     = match_s ? pos_s : idx;
      data    = match_s ? entries[pos_s].data : data;
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// write_back_buffer: posted-write buffer between the cache controller and main
// memory. Evictions are queued in a circular FIFO and drained to memory in the
// background; read-miss fills share the single memory port and are served from
// the buffer when it holds the requested address.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   wb_valid/addr/data    - eviction write offer; wb_ready accepts it
//   rd_req/rd_addr        - read-miss fill request (held until rd_valid)
//   rd_valid/rd_data      - one-cycle fill response
//   flush                 - forces draining ahead of read misses
//   empty, count          - buffer idle indicator and occupancy
//   mem_*                 - main-memory port (request held until mem_ready)
// ADDR_W/DATA_W must equal the package entry widths (WBB_ADDR_W/WBB_DATA_W).
module write_back_buffer import wbb_pkg::*; #(
  parameter  int DEPTH      = WBB_DEPTH,
  parameter  int ADDR_W     = WBB_ADDR_W,
  parameter  int DATA_W     = WBB_DATA_W,
  parameter  int HIGH_WATER = WBB_HIGH_WATER,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready
);

  wbb_state_e        state_r, state_nxt_s;
  wbb_entry_t        entries_r [DEPTH];
  logic [PTR_W-1:0]  head_r, tail_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] rd_data_r, rd_data_nxt_s;
  logic              load_rd_addr_s;

  logic [DEPTH-1:0]  head_excl_s;
  logic              wb_hit_s, rd_hit_s;
  logic [PTR_W-1:0]  wb_hit_idx_s, rd_hit_idx_s;
  logic [DATA_W-1:0] wb_hit_data_s, rd_hit_data_s;
  logic              wb_fire_s, merge_s, append_s, drain_done_s;
  logic              wb_fwd_s, rd_hit_any_s;
  logic              unused_s;

  // The head entry is only protected from merging while it is being written to memory.
  always_comb begin
    head_excl_s = '0;
    if (state_r == DRAIN) begin
      head_excl_s[head_r] = 1'b1;
    end else begin
      head_excl_s = '0;
    end
  end

  wbb_match #(.DEPTH(DEPTH)) u_wb_match (
    .entries (entries_r),
    .addr    (wb_addr),
    .excl    (head_excl_s),
    .tail    (tail_r),
    .hit     (wb_hit_s),
    .idx     (wb_hit_idx_s),
    .data    (wb_hit_data_s)
  );

  // No entry is in flight while IDLE, so read lookups need no exclusion.
  wbb_match #(.DEPTH(DEPTH)) u_rd_match (
    .entries (entries_r),
    .addr    (rd_addr),
    .excl    ({DEPTH{1'b0}}),
    .tail    (tail_r),
    .hit     (rd_hit_s),
    .idx     (rd_hit_idx_s),
    .data    (rd_hit_data_s)
  );

  assign unused_s = ^{wb_hit_data_s, rd_hit_idx_s};

  // A merge never needs a free slot, so a full buffer still accepts it.
  assign wb_ready     = (count_r < CNT_W'(DEPTH)) | wb_hit_s;
  assign wb_fire_s    = wb_valid & wb_ready;
  assign merge_s      = wb_fire_s & wb_hit_s;
  assign append_s     = wb_fire_s & ~wb_hit_s;
  assign drain_done_s = (state_r == DRAIN) & mem_ready;
  // A write landing this cycle on the read address is newer than anything stored.
  assign wb_fwd_s     = wb_fire_s & (wb_addr == rd_addr);
  assign rd_hit_any_s = rd_hit_s | wb_fwd_s;

  assign count_nxt_s  = count_r + {{(CNT_W-1){1'b0}}, append_s}
                                - {{(CNT_W-1){1'b0}}, drain_done_s};

  // Next-state and fill-data selection for the memory-port controller.
  always_comb begin
    state_nxt_s    = state_r;
    rd_data_nxt_s  = rd_data_r;
    load_rd_addr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_req && rd_hit_any_s) begin
          state_nxt_s   = RESP;
          rd_data_nxt_s = wb_fwd_s ? wb_data : rd_hit_data_s;
        end else if ((flush || (count_r >= CNT_W'(HIGH_WATER))) && (count_r != '0)) begin
          state_nxt_s = DRAIN;
        end else if (rd_req) begin
          state_nxt_s    = READ;
          load_rd_addr_s = 1'b1;
        end else if (count_r != '0) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      READ: begin
        if (mem_ready) begin
          state_nxt_s   = RESP;
          rd_data_nxt_s = mem_data_in;
        end else begin
          state_nxt_s = READ;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state, FIFO pointers, occupancy and captured read address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      rd_addr_r <= '0;
      rd_data_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      rd_data_r <= rd_data_nxt_s;
      if (append_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (drain_done_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (load_rd_addr_s) begin
        rd_addr_r <= rd_addr;
      end
    end
  end

  // Entry storage: append at tail, merge in place, retire the drained head.
  // The three cases never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (append_s && (tail_r == PTR_W'(i))) begin
          entries_r[i] <= '{valid: 1'b1, addr: wb_addr, data: wb_data};
        end else if (merge_s && (wb_hit_idx_s == PTR_W'(i))) begin
          entries_r[i].data <= wb_data;
        end else if (drain_done_s && (head_r == PTR_W'(i))) begin
          entries_r[i].valid <= 1'b0;
        end
      end
    end
  end

  // Memory-port drive decoded from the state register; head entry is stable during DRAIN.
  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    case (state_r)
      DRAIN: begin
        mem_address = entries_r[head_r].addr;
        mem_wdata   = entries_r[head_r].data;
      end
      READ: begin
        mem_address = rd_addr_r;
        mem_wdata   = '0;
      end
      default: begin
        mem_address = '0;
        mem_wdata   = '0;
      end
    endcase
  end

  assign mem_write = (state_r == DRAIN);
  assign mem_read  = (state_r == READ);
  assign rd_valid  = (state_r == RESP);
  assign rd_data   = rd_data_r;
  assign count     = count_r;
  assign empty     = (count_r == '0) && (state_r == IDLE);

endmodule
